// File: rtl/stdp_weight_updater_pkg.sv
// stdp_weight_updater_pkg: shared FSM states, update ops, weight type and LFSR constants for the STDP learning stage
package stdp_weight_updater_pkg;
  localparam int WBITS_DEF = 3;
  typedef logic [WBITS_DEF-1:0] weight_t;
  localparam weight_t WMAX = '1;
  typedef enum logic [1:0] {COLLECT, UPDATE, DONE} state_t;
  typedef enum logic [1:0] {HOLD, INC, DEC} op_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/stdp_weight_updater_sat_incdec.sv
// sat_incdec: combinational saturating +1/-1/hold on a W-bit value (val in, op select, res out)
module sat_incdec
  import stdp_weight_updater_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] val,
  input  op_t          op,
  output logic [W-1:0] res
);
  always_comb res = (op == INC && val != '1) ? val + W'(1) : (op == DEC && val != '0) ? val - W'(1) : val;
endmodule

// File: rtl/stdp_weight_updater.sv
// stdp_weight_updater: records first pre/post spike times per gamma window then applies STDP to one weight per cycle (clk, rst, spikes_in, spike_out, gamma_end in; weights, busy, update_done out; STDP_STOCHASTIC_EN gates updates with an LFSR)
module stdp_weight_updater
  import stdp_weight_updater_pkg::*;
#(
  parameter int NUM_SPIKES = 8,
  parameter int WBITS      = 3,
  parameter int WINIT      = 4,
  parameter int TBITS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SPIKES-1:0]       spikes_in,
  input  logic                        spike_out,
  input  logic                        gamma_end,
  output logic [NUM_SPIKES*WBITS-1:0] weights,
  output logic                        busy,
  output logic                        update_done
);
  localparam int KBITS = NUM_SPIKES > 1 ? $clog2(NUM_SPIKES) : 1;
  localparam logic [TBITS-1:0] TMAX = '1;
  state_t state, state_nxt;
  logic [KBITS-1:0] k;
  logic [TBITS-1:0] tcnt, t_post;
  logic [TBITS-1:0] t_pre [NUM_SPIKES];
  logic [NUM_SPIKES-1:0] pre_v;
  logic post_v, last;
  logic [WBITS-1:0] w [NUM_SPIKES];
  logic [WBITS-1:0] w_new;
  op_t op, op_rule;
  always_comb begin
    last = k == KBITS'(NUM_SPIKES - 1);
    state_nxt = state == COLLECT ? (gamma_end ? UPDATE : COLLECT) : state == UPDATE ? (last ? DONE : UPDATE) : COLLECT;
    busy = state == UPDATE;
    update_done = state == DONE;
    op_rule = !post_v ? HOLD : (pre_v[k] && t_pre[k] <= t_post) ? INC : DEC;
  end
`ifdef STDP_STOCHASTIC_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else if (state == UPDATE) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  assign op = lfsr[0] ? op_rule : HOLD;
`else
  assign op = op_rule;
`endif
  sat_incdec #(.W(WBITS)) u_sat (.val(w[k]), .op(op), .res(w_new));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= COLLECT;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt <= '0;
      t_post <= '0;
      pre_v <= '0;
      post_v <= 1'b0;
      k <= '0;
      for (int i = 0; i < NUM_SPIKES; i++) begin
        w[i] <= WBITS'(WINIT);
        t_pre[i] <= '0;
      end
    end else begin
      if (state == COLLECT) begin
        tcnt <= tcnt == TMAX ? tcnt : tcnt + 1'b1;
        k <= '0;
        for (int i = 0; i < NUM_SPIKES; i++)
          if (spikes_in[i] && !pre_v[i]) begin
            pre_v[i] <= 1'b1;
            t_pre[i] <= tcnt;
          end
        if (spike_out && !post_v) begin
          post_v <= 1'b1;
          t_post <= tcnt;
        end
      end
      if (state == UPDATE) begin
        w[k] <= w_new;
        k <= k + 1'b1;
      end
      if (state == DONE) begin
        pre_v <= '0;
        post_v <= 1'b0;
        tcnt <= '0;
      end
    end
  for (genvar g = 0; g < NUM_SPIKES; g++) assign weights[g*WBITS +: WBITS] = w[g];
endmodule

// File: tb/tb_stdp_weight_updater.sv
// tb_stdp_weight_updater: table-driven, hand-written and random windows checked against a window-level STDP model
module tb_stdp_weight_updater;
  localparam int N = 8;
  localparam int WB = 3;
  localparam int WI = 4;
  localparam int WM = (1 << WB) - 1;
  localparam int TM = 15;
  typedef struct {
    bit rst_first;
    logic [N-1:0] pre_mask;
    int tp;
    int tq;
    int len;
    int reps;
    logic [N*WB-1:0] exp;
  } vec_t;
  logic clk = 0, rst = 1, spike_out = 0, gamma_end = 0;
  logic [N-1:0] spikes_in = '0;
  logic [N*WB-1:0] weights;
  logic busy, update_done;
  int checks = 0, errors = 0;
  int mw [N];
  logic [15:0] mlfsr;
  int tpa [N];
  vec_t tbl [7];
  always #5 clk = ~clk;
  stdp_weight_updater dut (
    .clk(clk), .rst(rst), .spikes_in(spikes_in), .spike_out(spike_out),
    .gamma_end(gamma_end), .weights(weights), .busy(busy), .update_done(update_done)
  );
  function automatic logic [N*WB-1:0] pack_w(input int a [N]);
    logic [N*WB-1:0] r;
    for (int i = 0; i < N; i++) r[i*WB +: WB] = WB'(a[i]);
    return r;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) mw[i] = WI;
    mlfsr = 16'hACE1;
  endtask
  task automatic model_update(input int tpre [N], input int tpost, input int len, output int nw [N]);
    bit qv, pv;
    int qt, pt, d;
    qv = tpost >= 0 && tpost < len;
    qt = tpost > TM ? TM : tpost;
    for (int i = 0; i < N; i++) begin
      pv = tpre[i] >= 0 && tpre[i] < len;
      pt = tpre[i] > TM ? TM : tpre[i];
      d = !qv ? 0 : (pv && pt <= qt) ? 1 : -1;
`ifdef STDP_STOCHASTIC_EN
      if (!mlfsr[0]) d = 0;
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
`endif
      nw[i] = mw[i] + d;
      if (nw[i] < 0) nw[i] = 0;
      if (nw[i] > WM) nw[i] = WM;
    end
  endtask
  task automatic run_window(input int tpre [N], input int tpost, input int len, input bit noise, input int abort_at);
    int nw [N];
    int mix [N];
    int n;
    for (int t = 0; t < len; t++) begin
      check("stable", weights, pack_w(mw));
      for (int i = 0; i < N; i++)
        spikes_in[i] = tpre[i] >= 0 && (t == tpre[i] || (t > tpre[i] && $urandom_range(0, 1) == 1));
      spike_out = tpost >= 0 && (t == tpost || (t > tpost && $urandom_range(0, 1) == 1));
      gamma_end = t == len - 1;
      @(posedge clk);
      #1;
    end
    gamma_end = 0;
    spikes_in = '0;
    spike_out = 0;
    model_update(tpre, tpost, len, nw);
    n = 1;
    while (!update_done && n <= N + 3) begin
      if (n == abort_at) begin
        rst = 1;
        #1;
        for (int i = 0; i < N; i++) mix[i] = WI;
        check("abort_w", weights, pack_w(mix));
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        check("abort_done", update_done, 0);
        @(posedge clk);
        #1;
        check("abort_done2", update_done, 0);
        rst = 0;
        model_reset();
        return;
      end
      check("busy", busy, 1);
      for (int j = 0; j < N; j++) mix[j] = j < n - 1 ? nw[j] : mw[j];
      check("partial", weights, pack_w(mix));
      if (noise) begin
        spikes_in = N'($urandom);
        spike_out = 1;
        gamma_end = $urandom_range(0, 1) == 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    spikes_in = '0;
    spike_out = 0;
    gamma_end = 0;
    check("latency", n, N + 1);
    check("done_w", weights, pack_w(nw));
    check("done_busy", busy, 0);
    mw = nw;
    if (noise) begin
      gamma_end = 1;
      spikes_in = '1;
      spike_out = 1;
    end
    @(posedge clk);
    #1;
    gamma_end = 0;
    spikes_in = '0;
    spike_out = 0;
    check("done_pulse", update_done, 0);
    check("no_restart", busy, 0);
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{0, 8'h00, 0, -1, 5, 1, {8{3'd4}}};
    tbl[1] = '{0, 8'h04, 1, 3, 5, 1, {3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd3, 3'd3}};
    tbl[2] = '{0, 8'h20, 6, 2, 8, 5, {8{3'd0}}};
    tbl[3] = '{1, 8'h01, 0, 0, 3, 6, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[4] = '{1, 8'hFF, 2, -1, 4, 1, {8{3'd4}}};
    tbl[5] = '{0, 8'h80, 20, 17, 22, 1, {3'd5, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3}};
    tbl[6] = '{0, 8'h08, 4, 4, 5, 1, {3'd4, 3'd2, 3'd2, 3'd2, 3'd4, 3'd2, 3'd2, 3'd2}};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_w", weights, pack_w(mw));
    check("rst_busy", busy, 0);
    check("rst_done", update_done, 0);
    rst = 0;
    for (int e = 0; e < 7; e++) begin
      if (tbl[e].rst_first) begin
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
      end
      for (int i = 0; i < N; i++) tpa[i] = tbl[e].pre_mask[i] ? tbl[e].tp : -1;
      repeat (tbl[e].reps) run_window(tpa, tbl[e].tq, tbl[e].len, 0, -1);
`ifndef STDP_STOCHASTIC_EN
      check($sformatf("table%0d", e), weights, tbl[e].exp);
`endif
    end
    for (int i = 0; i < N; i++) tpa[i] = 0;
    run_window(tpa, 1, 3, 0, 3);
    for (int i = 0; i < N; i++) tpa[i] = i == 2 ? 1 : -1;
    run_window(tpa, 3, 5, 0, -1);
`ifndef STDP_STOCHASTIC_EN
    check("after_abort", weights, {3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd3, 3'd3});
`endif
    for (int i = 0; i < N; i++) tpa[i] = -1;
    run_window(tpa, -1, 4, 1, -1);
    run_window(tpa, -1, 3, 0, -1);
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) tpa[i] = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 20));
      run_window(tpa, $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 20)),
                 int'($urandom_range(1, 22)), $urandom_range(0, 1) == 1, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
